control_fsm: RTL

Parametrised multi-cycle control unit for the processor datapath. It owns its own step sequencer and replaces the externally driven `current_state` input with a `run`/`done` handshake. The instruction is latched into an internal instruction register when accepted, so changes or X values on `instruction` mid-execution have no effect. It drives the operand registers A and R, the ALU opcode, the operand multiplexers, the register-file one-hot write mask and the bus output enable, for a register file of parametrised size.

---
 rtl/control_fsm_if.sv | 52 +++++
 rtl/control_fsm.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/control_fsm_if.sv
//==============================================================================
// Module      : control_fsm_if
// Description : Handshake and datapath-control bundle between the control
//               unit and the processor datapath. Sized by the same parameters
//               as control_fsm.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface control_fsm_if #(
    parameter int INSTR_W    = 16,
    parameter int REG_ADDR_W = 3,
    parameter int DATA_W     = 16
) ();
    logic                         run;
    logic [INSTR_W-1:0]           instruction;
    logic                         busy;
    logic                         done;
    logic                         illegal_op;
    logic                         reg_a_enable;
    logic                         reg_r_enable;
    logic [2:0]                   alu_op_code;
    logic                         mux_sel_op_a;
    logic                         mux_sel_op_b;
    logic                         bus_mux_select;
    logic                         bus_output_enable;
    logic [REG_ADDR_W-1:0]        reg_read_addr_x;
    logic [REG_ADDR_W-1:0]        reg_read_addr_y;
    logic [REG_ADDR_W-1:0]        reg_write_addr;
    logic [(2**REG_ADDR_W)-1:0]   reg_file_write_enable_mask;
    logic [DATA_W-1:0]            immediate;

    // Requester / datapath side: issues run + instruction, observes controls.
    modport master (
        output run, instruction,
        input  busy, done, illegal_op, reg_a_enable, reg_r_enable, alu_op_code,
               mux_sel_op_a, mux_sel_op_b, bus_mux_select, bus_output_enable,
               reg_read_addr_x, reg_read_addr_y, reg_write_addr,
               reg_file_write_enable_mask, immediate
    );

    // Control unit side.
    modport slave (
        input  run, instruction,
        output busy, done, illegal_op, reg_a_enable, reg_r_enable, alu_op_code,
               mux_sel_op_a, mux_sel_op_b, bus_mux_select, bus_output_enable,
               reg_read_addr_x, reg_read_addr_y, reg_write_addr,
               reg_file_write_enable_mask, immediate
    );
endinterface

`default_nettype wire

// File: rtl/control_fsm.sv
//==============================================================================
// Module      : control_fsm
// Description : Multi-cycle control unit (IDLE -> T1 -> T2 -> T3) with an
//               internal instruction register and run/done handshake.
//               Optional macro CONTROL_FSM_MV_EN enables opcode 011 as MV.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module control_fsm #(
    parameter int INSTR_W    = 16,
    parameter int REG_ADDR_W = 3,
    parameter int DATA_W     = 16
) (
    input  wire logic       clock,
    input  wire logic       resetn,
    control_fsm_if.slave    bus
);

    localparam int c_IMM_W    = INSTR_W - 3 - 2*REG_ADDR_W;
    localparam int c_NUM_REGS = 2**REG_ADDR_W;

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_NAN = 3'b010;
    localparam logic [2:0] c_OP_MV  = 3'b011;
    localparam logic [2:0] c_OP_OUT = 3'b100;
    localparam logic [2:0] c_OP_LDI = 3'b101;
    localparam logic [2:0] c_OP_REP = 3'b111;

    localparam logic [2:0] c_ALU_ADD    = 3'b000;
    localparam logic [2:0] c_ALU_SUB    = 3'b001;
    localparam logic [2:0] c_ALU_NAN    = 3'b010;
    localparam logic [2:0] c_ALU_PASS_A = 3'b011;
    localparam logic [2:0] c_ALU_PASS_B = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_T3   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [INSTR_W-1:0]      r_ir;

    logic [2:0]              w_opcode;
    logic [REG_ADDR_W-1:0]   w_addr_x;
    logic [REG_ADDR_W-1:0]   w_addr_y;
    logic [c_IMM_W-1:0]      w_imm;
    logic [c_NUM_REGS-1:0]   w_onehot_x;
    logic                    w_op_writes;
    logic                    w_op_illegal;

    logic                    w_reg_a_enable;
    logic                    w_reg_r_enable;
    logic [2:0]              w_alu_op_code;
    logic                    w_mux_sel_op_a;
    logic                    w_mux_sel_op_b;
    logic                    w_bus_output_enable;
    logic                    w_illegal_op;
    logic [c_NUM_REGS-1:0]   w_write_mask;

    // Instruction register fields; IR is the only source once accepted.
    assign w_opcode   = r_ir[INSTR_W-1 -: 3];
    assign w_addr_x   = r_ir[INSTR_W-4 -: REG_ADDR_W];
    assign w_addr_y   = r_ir[INSTR_W-4-REG_ADDR_W -: REG_ADDR_W];
    assign w_imm      = r_ir[c_IMM_W-1:0];
    assign w_onehot_x = {{(c_NUM_REGS-1){1'b0}}, 1'b1} << w_addr_x;

    // State register and IR load on the edge leaving IDLE with run high.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && bus.run) begin
                r_ir <= bus.instruction;
            end
        end
    end

    // Classify the latched opcode: writes the register file, or illegal.
    always_comb begin
        w_op_writes  = 1'b0;
        w_op_illegal = 1'b0;
        case (w_opcode)
            c_OP_ADD, c_OP_SUB, c_OP_NAN,
            c_OP_LDI, c_OP_REP:          w_op_writes  = 1'b1;
            c_OP_OUT:                    w_op_writes  = 1'b0;
`ifdef CONTROL_FSM_MV_EN
            c_OP_MV:                     w_op_writes  = 1'b1;
`else
            c_OP_MV:                     w_op_illegal = 1'b1;
`endif
            default:                     w_op_illegal = 1'b1;
        endcase
    end

    // Next-state sequencing and Moore decode of all control outputs.
    always_comb begin
        w_state_next        = r_state;
        w_reg_a_enable      = 1'b0;
        w_reg_r_enable      = 1'b0;
        w_alu_op_code       = c_ALU_ADD;
        w_mux_sel_op_a      = 1'b0;
        w_mux_sel_op_b      = 1'b0;
        w_bus_output_enable = 1'b0;
        w_illegal_op        = 1'b0;
        w_write_mask        = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.run) begin
                    w_state_next = S_T1;
                end
            end
            S_T1: begin
                w_state_next   = S_T2;
                w_reg_a_enable = 1'b1;
                w_mux_sel_op_a = (w_opcode == c_OP_LDI);
            end
            S_T2: begin
                w_state_next = S_T3;
                case (w_opcode)
                    c_OP_ADD: begin w_reg_r_enable = 1'b1; w_alu_op_code = c_ALU_ADD; end
                    c_OP_SUB: begin w_reg_r_enable = 1'b1; w_alu_op_code = c_ALU_SUB; end
                    c_OP_NAN: begin w_reg_r_enable = 1'b1; w_alu_op_code = c_ALU_NAN; end
                    c_OP_LDI: begin
                        w_reg_r_enable = 1'b1;
                        w_alu_op_code  = c_ALU_PASS_A;
                        w_mux_sel_op_b = 1'b1;
                    end
                    c_OP_REP: begin w_reg_r_enable = 1'b1; w_alu_op_code = c_ALU_PASS_B; end
`ifdef CONTROL_FSM_MV_EN
                    c_OP_MV:  begin w_reg_r_enable = 1'b1; w_alu_op_code = c_ALU_PASS_B; end
`endif
                    default: begin
                        w_reg_r_enable = 1'b0;
                    end
                endcase
            end
            S_T3: begin
                w_state_next        = S_IDLE;
                w_write_mask        = w_op_writes ? w_onehot_x : '0;
                w_bus_output_enable = (w_opcode == c_OP_OUT);
                w_illegal_op        = w_op_illegal;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Immediate field zero-extended or truncated to the datapath width.
    generate
        if (DATA_W > c_IMM_W) begin : g_imm_zext
            assign bus.immediate = {{(DATA_W-c_IMM_W){1'b0}}, w_imm};
        end else begin : g_imm_trunc
            assign bus.immediate = w_imm[DATA_W-1:0];
        end
    endgenerate

    assign bus.busy                       = (r_state != S_IDLE);
    assign bus.done                       = (r_state == S_T3);
    assign bus.illegal_op                 = w_illegal_op;
    assign bus.reg_a_enable               = w_reg_a_enable;
    assign bus.reg_r_enable               = w_reg_r_enable;
    assign bus.alu_op_code                = w_alu_op_code;
    assign bus.mux_sel_op_a               = w_mux_sel_op_a;
    assign bus.mux_sel_op_b               = w_mux_sel_op_b;
    assign bus.bus_mux_select             = 1'b0;
    assign bus.bus_output_enable          = w_bus_output_enable;
    assign bus.reg_read_addr_x            = w_addr_x;
    assign bus.reg_read_addr_y            = w_addr_y;
    assign bus.reg_write_addr             = w_addr_x;
    assign bus.reg_file_write_enable_mask = w_write_mask;

endmodule

`default_nettype wire
